// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - UART-fed instruction memory loader with registered read port.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte after the data words.

module uart_rx #(
  parameter int CLK_PER_HALF_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rx_ready,
  output logic       ferr
);
  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);

  typedef enum logic [2:0] {R_IDLE, R_START, R_BITS, R_STOP, R_BREAK} rx_state_t;

  rx_state_t      r_state;
  logic [1:0]     r_sync;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bit;
  logic [7:0]     r_shift;
  logic           w_rx;

  assign w_rx = r_sync[1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= R_IDLE;
      r_sync   <= 2'b11;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      rdata    <= '0;
      rx_ready <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], rxd};
      rx_ready <= 1'b0;
      ferr     <= 1'b0;
      case (r_state)
        R_IDLE: begin
          r_cnt <= '0;
          if (!w_rx) r_state <= R_START;
        end
        R_START: begin
          if (r_cnt == CW'(CLK_PER_HALF_BIT - 1)) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx ? R_IDLE : R_BITS;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        R_BITS: begin
          if (r_cnt == CW'(2 * CLK_PER_HALF_BIT - 1)) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= R_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        R_STOP: begin
          if (r_cnt == CW'(2 * CLK_PER_HALF_BIT - 1)) begin
            r_cnt <= '0;
            if (w_rx) begin
              rdata    <= r_shift;
              rx_ready <= 1'b1;
              r_state  <= R_IDLE;
            end else begin
              ferr    <= 1'b1;
              r_state <= R_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // A low stop bit must not be mistaken for the next start bit.
        R_BREAK: if (w_rx) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

module imem_uart_loader #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int ADDR_W           = 10,
  parameter int XLEN             = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  input  logic              mode,
  input  logic [ADDR_W+1:0] pc,
  output logic [XLEN-1:0]   inst,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W:0]   word_cnt
);
  localparam int B   = XLEN / 8;
  localparam int BCW = (B > 4) ? $clog2(B) : 2;

`ifdef IMEM_LOADER_CSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR, S_CSUM} state_t;
  localparam state_t S_FIN    = S_CSUM;
  localparam logic   FIN_BUSY = 1'b1;
  logic [7:0] r_csum;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_FIN    = S_DONE;
  localparam logic   FIN_BUSY = 1'b0;
`endif

  state_t           r_state;
  logic             r_done, r_err, r_busy;
  logic [ADDR_W:0]  r_word_cnt, r_n;
  logic [BCW-1:0]   r_byte_cnt;
  logic [23:0]      r_hdr;
  logic [XLEN-1:0]  r_shift, r_inst;
  logic [XLEN-1:0]  r_mem [2**ADDR_W];

  logic [7:0]       w_rdata;
  logic             w_rx_ready, w_ferr;
  logic [XLEN+7:0]  w_cat;
  logic [XLEN-1:0]  w_wdata;
  logic [31:0]      w_hdr_n;
  logic             w_hdr_big, w_hdr_zero, w_word_done, w_last_word, w_we;
  logic             w_unused;

  uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
    .rdata(w_rdata), .rx_ready(w_rx_ready), .ferr(w_ferr),
    .rxd(rxd), .clk(clk), .rstn(rstn)
  );

  assign w_cat       = {r_shift, w_rdata};
  assign w_wdata     = w_cat[XLEN-1:0];
  assign w_hdr_n     = {r_hdr, w_rdata};
  assign w_hdr_big   = {1'b0, w_hdr_n} > (33'd1 << ADDR_W);
  assign w_hdr_zero  = (w_hdr_n == 32'd0);
  assign w_word_done = (r_state == S_DATA) && w_rx_ready && (r_byte_cnt == BCW'(B - 1));
  assign w_last_word = (r_word_cnt + {{ADDR_W{1'b0}}, 1'b1}) == r_n;
  assign w_we        = rstn && mode && w_word_done;
  assign w_unused    = ^{pc[1:0], w_cat[XLEN+7:XLEN]};

  assign inst     = r_inst;
  assign done     = r_done;
  assign err      = r_err;
  assign busy     = r_busy;
  assign word_cnt = r_word_cnt;

  // Memory has no reset; the read returns pre-write data on a same-address collision.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_word_cnt[ADDR_W-1:0]] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_inst <= '0;
    else       r_inst <= r_mem[pc[ADDR_W+1:2]];
  end

  always_ff @(posedge clk) begin
    if (!rstn || !mode) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_word_cnt <= '0;
      r_n        <= '0;
      r_byte_cnt <= '0;
      r_hdr      <= '0;
      r_shift    <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_HDR;
          r_busy  <= 1'b1;
        end
        S_HDR: begin
          if (w_ferr) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_rx_ready) begin
            r_hdr <= w_hdr_n[23:0];
            if (r_byte_cnt == BCW'(3)) begin
              r_byte_cnt <= '0;
              r_n        <= w_hdr_n[ADDR_W:0];
              if (w_hdr_big) begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
              end else if (w_hdr_zero) begin
                r_state <= S_FIN;
                r_busy  <= FIN_BUSY;
                r_done  <= ~FIN_BUSY;
              end else begin
                r_state <= S_DATA;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + BCW'(1);
            end
          end
        end
        S_DATA: begin
          if (w_ferr) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_rx_ready) begin
            r_shift <= w_wdata;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum  <= r_csum ^ w_rdata;
`endif
            if (w_word_done) begin
              r_byte_cnt <= '0;
              r_word_cnt <= r_word_cnt + {{ADDR_W{1'b0}}, 1'b1};
              if (w_last_word) begin
                r_state <= S_FIN;
                r_busy  <= FIN_BUSY;
                r_done  <= ~FIN_BUSY;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + BCW'(1);
            end
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM: begin
          if (w_ferr || (w_rx_ready && w_rdata != r_csum)) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_rx_ready) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - scoreboard bench for imem_uart_loader.

module tb_imem_uart_loader;
  localparam int HB     = 4;
  localparam int BIT    = 2 * HB;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rstn, rxd, mode;
  logic [ADDR_W+1:0] pc;
  logic [31:0]       inst;
  logic              done, err, busy;
  logic [ADDR_W:0]   word_cnt;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] model [0:(1<<ADDR_W)-1];
  logic [31:0] exp_q [$];

  imem_uart_loader #(.CLK_PER_HALF_BIT(HB), .ADDR_W(ADDR_W), .XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .mode(mode), .pc(pc),
    .inst(inst), .done(done), .err(err), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic status(input string tag, input logic d, input logic e, input logic b,
                        input int wc);
    @(negedge clk);
    check({tag, ".done"}, done, d);
    check({tag, ".err"}, err, e);
    check({tag, ".busy"}, busy, b);
    check({tag, ".word_cnt"}, word_cnt, wc);
  endtask

  task automatic rd(input int addr);
    @(negedge clk);
    pc = (ADDR_W + 2)'(addr * 4);
    exp_q.push_back(model[addr]);
    @(negedge clk);
    check($sformatf("inst@%0d", addr), inst, exp_q.pop_front());
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic load_start();
    @(negedge clk);
    mode = 1'b0;
    repeat (2) @(negedge clk);
    mode = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; mode = 1'b0; rxd = 1'b1; pc = '0;
    repeat (3) @(negedge clk);
    check("rst.inst", inst, 32'h0);
    status("rst", 1'b0, 1'b0, 1'b0, 0);
    rstn = 1'b1;

    load_start();
    check("hdr.busy", busy, 1'b1);
    send_word(32'd2);
    send_word(32'h0000_0013); model[0] = 32'h0000_0013;
    send_word(32'hDEAD_BEEF); model[1] = 32'hDEAD_BEEF;
    status("load2", 1'b1, 1'b0, 1'b0, 2);
    rd(0);
    rd(1);
    send_byte(8'h55);
    status("after_done", 1'b1, 1'b0, 1'b0, 2);
    rd(0);

    load_start();
    send_word(32'd0);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h00);
`endif
    status("n0", 1'b1, 1'b0, 1'b0, 0);

    load_start();
    send_word(32'd1025);
    status("n1025", 1'b0, 1'b1, 1'b0, 0);
    rd(0);
    rd(1);

    load_start();
    send_word(32'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC, 1'b0);
    status("ferr", 1'b0, 1'b1, 1'b0, 0);
    @(negedge clk) mode = 1'b0;
    status("ferr_clr", 1'b0, 1'b0, 1'b0, 0);
    load_start();
    send_word(32'd2);
    send_word(32'hCAFE_F00D); model[0] = 32'hCAFE_F00D;
    send_word(32'h1234_5678); model[1] = 32'h1234_5678;
    status("reload", 1'b1, 1'b0, 1'b0, 2);
    rd(0);
    rd(1);

    load_start();
    send_word(32'd2);
    send_word(32'hA5A5_0001); model[0] = 32'hA5A5_0001;
    send_byte(8'h77);
    @(negedge clk) mode = 1'b0;
    status("mode_drop", 1'b0, 1'b0, 1'b0, 0);
    rd(0);
    rd(1);

    load_start();
    send_word(32'd1);
    send_byte(8'h11);
    @(negedge clk) rstn = 1'b0;
    status("rst_mid", 1'b0, 1'b0, 1'b0, 0);
    check("rst_mid.inst", inst, 32'h0);
    rstn = 1'b1;
    rd(0);

`ifdef IMEM_LOADER_CSUM_EN
    load_start();
    send_word(32'd1);
    send_word(32'h0102_0304); model[0] = 32'h0102_0304;
    send_byte(8'h04);
    status("csum_ok", 1'b1, 1'b0, 1'b0, 1);
    load_start();
    send_word(32'd1);
    send_word(32'h0102_0304);
    send_byte(8'h05);
    status("csum_bad", 1'b0, 1'b1, 1'b0, 1);
    rd(0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
